dmem_arbiter: RTL and testbench

//  Shares the single dmem R/W port of the softcore memory between two requesters:

---
 rtl/mem_pkg.sv | 27 ++
 rtl/dmem_align_chk.sv | 27 ++
 rtl/dmem_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types for the dmem arbiter: access size, read-ownership tag and memory request payload.
package mem_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_C    = 2'd1,
        OWN_L    = 2'd2
    } owner_e;

    typedef struct packed {
        logic              write;
        logic              op_byte;
        logic              op_hwrd;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/dmem_align_chk.sv
// Decodes access size into memory op selects and flags addresses not aligned to that size.
module dmem_align_chk
    import mem_pkg::*;
(
    input  logic [1:0] size,
    input  logic [1:0] addr_lo,
    output logic       misaligned,
    output logic       op_byte,
    output logic       op_hwrd
);

    always_comb begin
        misaligned = 1'b0;
        op_byte    = 1'b0;
        op_hwrd    = 1'b0;
        case (size_e'(size))
            SZ_BYTE: op_byte = 1'b1;
            SZ_HALF: begin
                op_hwrd    = 1'b1;
                misaligned = addr_lo[0];
            end
            // Undefined size codes are checked as word accesses
            default: misaligned = |addr_lo;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port (CPU C / loader L) arbiter onto the single dmem R/W port with lock, starvation relief
// and read-return steering. Define DMEM_ARB_RR_EN for round-robin instead of fixed C>L priority.
module dmem_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,

    input  logic        i_c_valid,
    input  logic        i_c_write,
    input  logic [1:0]  i_c_size,
    input  logic [31:0] i_c_addr,
    input  logic [31:0] i_c_wdata,
    output logic        o_c_ready,
    output logic        o_c_rvalid,
    output logic        o_c_err,
    output logic [31:0] o_c_rdata,

    input  logic        i_l_valid,
    input  logic        i_l_write,
    input  logic [1:0]  i_l_size,
    input  logic [31:0] i_l_addr,
    input  logic [31:0] i_l_wdata,
    input  logic        i_l_lock,
    output logic        o_l_ready,
    output logic        o_l_rvalid,
    output logic        o_l_err,
    output logic [31:0] o_l_rdata,

    output logic        o_mem_write,
    output logic        o_mem_op_byte,
    output logic        o_mem_op_hwrd,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata
);

    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

    logic             c_mis, c_byte, c_hwrd;
    logic             l_mis, l_byte, l_hwrd;
    logic             lock_q, lock_nxt;
    logic [CNT_W-1:0] starve_cnt, cnt_nxt;
    owner_e           rd_owner, owner_nxt;
    logic             rd_err, err_nxt;
    logic             locked, force_c;
    logic             grant_c, grant_l;
    logic             c_acc, l_acc;
    mem_req_t         req;
`ifdef DMEM_ARB_RR_EN
    logic             rr_prefer_l, rr_nxt;
`endif

    dmem_align_chk u_c_align (
        .size       (i_c_size),
        .addr_lo    (i_c_addr[1:0]),
        .misaligned (c_mis),
        .op_byte    (c_byte),
        .op_hwrd    (c_hwrd)
    );

    dmem_align_chk u_l_align (
        .size       (i_l_size),
        .addr_lo    (i_l_addr[1:0]),
        .misaligned (l_mis),
        .op_byte    (l_byte),
        .op_hwrd    (l_hwrd)
    );

    // Grant selection: starvation relief beats lock, lock beats normal arbitration
    always_comb begin
        grant_c = 1'b0;
        grant_l = 1'b0;
        locked  = lock_q & i_l_valid;
        force_c = locked & i_c_valid & (starve_cnt == CNT_W'(STARVE_MAX));
        if (i_rst_n) begin
            if (force_c) begin
                grant_c = 1'b1;
            end else if (locked) begin
                grant_l = 1'b1;
            end
`ifdef DMEM_ARB_RR_EN
            else if (i_c_valid && i_l_valid) begin
                grant_c = ~rr_prefer_l;
                grant_l = rr_prefer_l;
            end
`endif
            else if (i_c_valid) begin
                grant_c = 1'b1;
            end else begin
                grant_l = i_l_valid;
            end
        end
    end

    assign c_acc     = grant_c & i_c_valid;
    assign l_acc     = grant_l & i_l_valid;
    assign o_c_ready = c_acc;
    assign o_l_ready = l_acc;

    // Misaligned accesses are accepted but never reach memory
    always_comb begin
        req = '0;
        if (c_acc && !c_mis) begin
            req = '{write: i_c_write, op_byte: c_byte, op_hwrd: c_hwrd,
                    addr: i_c_addr, wdata: i_c_wdata};
        end else if (l_acc && !l_mis) begin
            req = '{write: i_l_write, op_byte: l_byte, op_hwrd: l_hwrd,
                    addr: i_l_addr, wdata: i_l_wdata};
        end
    end

    assign o_mem_write   = req.write;
    assign o_mem_op_byte = req.op_byte;
    assign o_mem_op_hwrd = req.op_hwrd;
    assign o_mem_addr    = req.addr;
    assign o_mem_wdata   = req.wdata;

    always_comb begin
        owner_nxt = OWN_NONE;
        err_nxt   = 1'b0;
        if (c_acc && (c_mis || !i_c_write)) begin
            owner_nxt = OWN_C;
            err_nxt   = c_mis;
        end else if (l_acc && (l_mis || !i_l_write)) begin
            owner_nxt = OWN_L;
            err_nxt   = l_mis;
        end

        lock_nxt = lock_q;
        if (!i_l_valid || !i_l_lock) begin
            lock_nxt = 1'b0;
        end else if (l_acc) begin
            lock_nxt = 1'b1;
        end

        // Saturating count of C cycles spent waiting behind the lock
        cnt_nxt = starve_cnt;
        if (!lock_nxt || c_acc) begin
            cnt_nxt = '0;
        end else if (locked && i_c_valid && (starve_cnt != CNT_W'(STARVE_MAX))) begin
            cnt_nxt = starve_cnt + CNT_W'(1);
        end

`ifdef DMEM_ARB_RR_EN
        rr_nxt = rr_prefer_l;
        if (c_acc) begin
            rr_nxt = 1'b1;
        end else if (l_acc) begin
            rr_nxt = 1'b0;
        end
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lock_q      <= 1'b0;
            starve_cnt  <= '0;
            rd_owner    <= OWN_NONE;
            rd_err      <= 1'b0;
`ifdef DMEM_ARB_RR_EN
            rr_prefer_l <= 1'b0;
`endif
        end else begin
            lock_q      <= lock_nxt;
            starve_cnt  <= cnt_nxt;
            rd_owner    <= owner_nxt;
            rd_err      <= err_nxt;
`ifdef DMEM_ARB_RR_EN
            rr_prefer_l <= rr_nxt;
`endif
        end
    end

    // Read return steered to the issuing port only; errors return zero data
    assign o_c_rvalid = (rd_owner == OWN_C);
    assign o_l_rvalid = (rd_owner == OWN_L);
    assign o_c_err    = o_c_rvalid & rd_err;
    assign o_l_err    = o_l_rvalid & rd_err;
    assign o_c_rdata  = (o_c_rvalid && !rd_err) ? i_mem_rdata : '0;
    assign o_l_rdata  = (o_l_rvalid && !rd_err) ? i_mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed scoreboard bench for dmem_arbiter with a small byte-lane memory model.
module tb_dmem_arbiter;
    import mem_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_c_valid, i_c_write;
    logic [1:0]  i_c_size;
    logic [31:0] i_c_addr, i_c_wdata;
    logic        o_c_ready, o_c_rvalid, o_c_err;
    logic [31:0] o_c_rdata;
    logic        i_l_valid, i_l_write, i_l_lock;
    logic [1:0]  i_l_size;
    logic [31:0] i_l_addr, i_l_wdata;
    logic        o_l_ready, o_l_rvalid, o_l_err;
    logic [31:0] o_l_rdata;
    logic        o_mem_write, o_mem_op_byte, o_mem_op_hwrd;
    logic [31:0] o_mem_addr, o_mem_wdata;
    logic [31:0] i_mem_rdata;

    always #5 i_clk = ~i_clk;

    dmem_arbiter #(.STARVE_MAX(16)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_c_valid(i_c_valid), .i_c_write(i_c_write), .i_c_size(i_c_size),
        .i_c_addr(i_c_addr), .i_c_wdata(i_c_wdata), .o_c_ready(o_c_ready),
        .o_c_rvalid(o_c_rvalid), .o_c_err(o_c_err), .o_c_rdata(o_c_rdata),
        .i_l_valid(i_l_valid), .i_l_write(i_l_write), .i_l_size(i_l_size),
        .i_l_addr(i_l_addr), .i_l_wdata(i_l_wdata), .i_l_lock(i_l_lock),
        .o_l_ready(o_l_ready), .o_l_rvalid(o_l_rvalid), .o_l_err(o_l_err),
        .o_l_rdata(o_l_rdata),
        .o_mem_write(o_mem_write), .o_mem_op_byte(o_mem_op_byte),
        .o_mem_op_hwrd(o_mem_op_hwrd), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } resp_t;

    resp_t qc[$];
    resp_t ql[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    logic [31:0] mem [256];
    logic        mem_init = 1'b0;

    // Memory model: lane-aligned writes, reads registered one cycle after issue
    always @(posedge i_clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
            mem[4]   <= 32'hDEADBEEF;
            mem_init <= 1'b1;
        end else if (o_mem_write) begin
            if (o_mem_op_byte)
                mem[o_mem_addr[9:2]][{o_mem_addr[1:0], 3'b000} +: 8] <=
                    o_mem_wdata[{o_mem_addr[1:0], 3'b000} +: 8];
            else if (o_mem_op_hwrd)
                mem[o_mem_addr[9:2]][{o_mem_addr[1], 4'b0000} +: 16] <=
                    o_mem_wdata[{o_mem_addr[1], 4'b0000} +: 16];
            else
                mem[o_mem_addr[9:2]] <= o_mem_wdata;
        end
        i_mem_rdata <= mem[o_mem_addr[9:2]];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Response monitor: every rvalid must match the oldest expectation for that port
    always @(negedge i_clk) begin
        if (o_c_rvalid) begin
            if (qc.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL c_unexpected_rvalid: got rvalid=1 expected 0 at %0t", $time);
            end else begin
                resp_t e;
                e = qc.pop_front();
                check("c_rdata", o_c_rdata, e.data);
                check1("c_err", o_c_err, e.err);
            end
        end
        if (o_l_rvalid) begin
            if (ql.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL l_unexpected_rvalid: got rvalid=1 expected 0 at %0t", $time);
            end else begin
                resp_t e;
                e = ql.pop_front();
                check("l_rdata", o_l_rdata, e.data);
                check1("l_err", o_l_err, e.err);
            end
        end
    end

    task automatic set_c(input logic v, input logic w, input size_e sz,
                         input logic [31:0] a, input logic [31:0] d);
        i_c_valid = v; i_c_write = w; i_c_size = sz; i_c_addr = a; i_c_wdata = d;
    endtask

    task automatic set_l(input logic v, input logic w, input size_e sz,
                         input logic [31:0] a, input logic [31:0] d, input logic lk);
        i_l_valid = v; i_l_write = w; i_l_size = sz; i_l_addr = a; i_l_wdata = d; i_l_lock = lk;
    endtask

    task automatic idle();
        set_c(1'b0, 1'b0, SZ_WORD, 32'h0, 32'h0);
        set_l(1'b0, 1'b0, SZ_WORD, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [31:0] ca, la;
        logic        exp_c;
        idle();

        // Reset held with both ports requesting
        set_c(1'b1, 1'b0, SZ_WORD, 32'h0, 32'h0);
        set_l(1'b1, 1'b0, SZ_WORD, 32'h4, 32'h0, 1'b0);
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        check1("rst_c_ready", o_c_ready, 1'b0);
        check1("rst_l_ready", o_l_ready, 1'b0);
        check1("rst_c_rvalid", o_c_rvalid, 1'b0);
        check1("rst_l_rvalid", o_l_rvalid, 1'b0);
        check1("rst_mem_write", o_mem_write, 1'b0);
        check("rst_mem_addr", o_mem_addr, 32'h0);
        tick();
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check1("rel_c_ready", o_c_ready, 1'b1);
        check1("rel_l_ready", o_l_ready, 1'b0);
        qc.push_back('{data: 32'h0, err: 1'b0});
        tick();
        set_c(1'b0, 1'b0, SZ_WORD, 32'h0, 32'h0);
        @(negedge i_clk);
        check1("rel_l_ready2", o_l_ready, 1'b1);
        check("rel_l_addr", o_mem_addr, 32'h4);
        ql.push_back('{data: 32'h0, err: 1'b0});
        tick();
        idle();

        // C word read
        set_c(1'b1, 1'b0, SZ_WORD, 32'h10, 32'h0);
        @(negedge i_clk);
        check1("t2_c_ready", o_c_ready, 1'b1);
        check("t2_mem_addr", o_mem_addr, 32'h10);
        check1("t2_mem_write", o_mem_write, 1'b0);
        qc.push_back('{data: 32'hDEADBEEF, err: 1'b0});
        tick();
        idle();
        @(negedge i_clk);
        check1("t2_c_rvalid", o_c_rvalid, 1'b1);
        check1("t2_l_rvalid", o_l_rvalid, 1'b0);
        tick();

        // Reset while a read is outstanding drops the response
        set_c(1'b1, 1'b0, SZ_WORD, 32'h10, 32'h0);
        @(negedge i_clk);
        check1("rr_c_ready", o_c_ready, 1'b1);
        i_rst_n = 1'b0;
        idle();
        @(negedge i_clk);
        check1("rr_c_rvalid", o_c_rvalid, 1'b0);
        tick();
        i_rst_n = 1'b1;

        // Both ports storing every cycle
        ca = 32'h40;
        la = 32'h80;
        for (int i = 0; i < 4; i++) begin
            set_c(1'b1, 1'b1, SZ_WORD, ca, 32'h1000 + 32'(i));
            set_l(1'b1, 1'b1, SZ_WORD, la, 32'h2000 + 32'(i), 1'b0);
            @(negedge i_clk);
`ifdef DMEM_ARB_RR_EN
            exp_c = (i % 2 == 0);
`else
            exp_c = 1'b1;
`endif
            check1("t3_c_ready", o_c_ready, exp_c);
            check1("t3_l_ready", o_l_ready, !exp_c);
            check1("t3_mem_write", o_mem_write, 1'b1);
            check("t3_mem_addr", o_mem_addr, exp_c ? ca : la);
            if (exp_c) ca = ca + 32'h4;
            else       la = la + 32'h4;
            tick();
        end
        idle();
        tick();

        // L lock with C starving
        la = 32'h200;
        set_l(1'b1, 1'b1, SZ_WORD, la, 32'hA5A5A5A5, 1'b1);
        @(negedge i_clk);
        check1("t4_lock_l_ready", o_l_ready, 1'b1);
        tick();
        la = la + 32'h4;
        set_l(1'b1, 1'b1, SZ_WORD, la, 32'hA5A5A5A5, 1'b1);
        set_c(1'b1, 1'b1, SZ_WORD, 32'h100, 32'h55555555);
        for (int i = 0; i < 16; i++) begin
            @(negedge i_clk);
            check1("t4_l_hold", o_l_ready, 1'b1);
            check1("t4_c_wait", o_c_ready, 1'b0);
            tick();
            la = la + 32'h4;
            set_l(1'b1, 1'b1, SZ_WORD, la, 32'hA5A5A5A5, 1'b1);
        end
        @(negedge i_clk);
        check1("t4_c_forced", o_c_ready, 1'b1);
        check1("t4_l_paused", o_l_ready, 1'b0);
        check("t4_c_addr", o_mem_addr, 32'h100);
        tick();
        set_c(1'b1, 1'b1, SZ_WORD, 32'h104, 32'h66666666);
        @(negedge i_clk);
        check1("t4_l_resume", o_l_ready, 1'b1);
        check1("t4_c_again_wait", o_c_ready, 1'b0);
        check("t4_l_addr", o_mem_addr, la);
        tick();
        idle();
        tick();

        // Misaligned load and store
        set_c(1'b1, 1'b0, SZ_HALF, 32'h3, 32'h0);
        @(negedge i_clk);
        check1("t5_c_ready", o_c_ready, 1'b1);
        check1("t5_mem_write", o_mem_write, 1'b0);
        check("t5_mem_addr", o_mem_addr, 32'h0);
        check1("t5_op_hwrd", o_mem_op_hwrd, 1'b0);
        qc.push_back('{data: 32'h0, err: 1'b1});
        tick();
        idle();
        set_l(1'b1, 1'b1, SZ_WORD, 32'h22, 32'hFFFFFFFF, 1'b0);
        @(negedge i_clk);
        check1("t5_l_ready", o_l_ready, 1'b1);
        check1("t5_l_mem_write", o_mem_write, 1'b0);
        check("t5_l_wdata", o_mem_wdata, 32'h0);
        ql.push_back('{data: 32'h0, err: 1'b1});
        tick();
        idle();

        // Byte store then reads back-to-back
        set_l(1'b1, 1'b1, SZ_BYTE, 32'h21, 32'h0000AB00, 1'b0);
        @(negedge i_clk);
        check1("t6_l_ready", o_l_ready, 1'b1);
        check1("t6_mem_write", o_mem_write, 1'b1);
        check1("t6_op_byte", o_mem_op_byte, 1'b1);
        check1("t6_op_hwrd", o_mem_op_hwrd, 1'b0);
        check("t6_addr", o_mem_addr, 32'h21);
        check("t6_wdata", o_mem_wdata, 32'h0000AB00);
        tick();
        idle();
        set_c(1'b1, 1'b0, SZ_WORD, 32'h20, 32'h0);
        @(negedge i_clk);
        check1("t6_rd_ready", o_c_ready, 1'b1);
        qc.push_back('{data: 32'h0000AB00, err: 1'b0});
        tick();
        set_c(1'b1, 1'b0, SZ_HALF, 32'h22, 32'h0);
        @(negedge i_clk);
        check1("t6_h_ready", o_c_ready, 1'b1);
        check1("t6_h_op_hwrd", o_mem_op_hwrd, 1'b1);
        check1("t6_h_op_byte", o_mem_op_byte, 1'b0);
        check("t6_h_addr", o_mem_addr, 32'h22);
        qc.push_back('{data: 32'h0000AB00, err: 1'b0});
        tick();
        set_c(1'b1, 1'b0, SZ_WORD, 32'h10, 32'h0);
        @(negedge i_clk);
        check1("t6_b2b_ready", o_c_ready, 1'b1);
        qc.push_back('{data: 32'hDEADBEEF, err: 1'b0});
        tick();
        idle();
        repeat (3) tick();

        check("qc_drained", 32'(qc.size()), 32'h0);
        check("ql_drained", 32'(ql.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
